session_rcv: RTL and testbench
==============================

SESSION_RCV -- requirements
Module: session_rcv

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets the audio sample FIFO entries; power of two, 2..64.
REQ-002 Parameter RING_TIMEOUT, default 24'd1000000, sets the clk cycles spent in RINGING before auto-return to IDLE.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sendingToSession  input  2  word type from the transport receiver: 00 none, 01 audio sample, 10 control word, 11 reserved.
REQ-006 data  input  16  word qualified by sendingToSession.
REQ-007 sessionBusy  output  1  backpressure to the transport receiver; high means the word is not accepted this cycle.
REQ-008 sample_req  input  1  one-cycle pop strobe from the audio side (sample rate).
REQ-009 audio_out  output  16  sample presented to the audio side.
REQ-010 audio_valid  output  1  one-cycle pulse; audio_out is valid in this cycle.
REQ-011 call_state  output  2  00 IDLE, 01 RINGING, 10 CONNECTED.
REQ-012 ring  output  1  high exactly while call_state is RINGING.
REQ-013 err_pulse  output  1  one-cycle pulse on any rejected or illegal input word.

Function
REQ-014 A word is accepted on a rising edge when sendingToSession is not 00 and sessionBusy is 0.
REQ-015 sessionBusy SHALL be a combinational function of registered state only: high when FIFO count equals FIFO_DEPTH, or in the cycle after a control word is accepted (ctrl_hold).
REQ-016 Accepted audio word in CONNECTED: written to the FIFO tail and count increments.
REQ-017 Accepted audio word outside CONNECTED: dropped silently, with no err_pulse.
REQ-018 A word presented (type not 00) while sessionBusy is high is not accepted; err_pulse is raised in the next cycle.
REQ-019 Control word: data[15:8] is the opcode and data[7:0] is reserved. Opcodes are 01 RING, 02 ANSWER, 03 HANGUP.
REQ-020 State transitions:
  - IDLE -RING-> RINGING, clearing the ring timer.
  - RINGING -ANSWER-> CONNECTED.
  - RINGING -(timer reaches RING_TIMEOUT-1)-> IDLE.
  - any state -HANGUP-> IDLE, flushing the FIFO (count, head and tail set to 0).
REQ-021 An opcode not legal in the current state, an unknown opcode, or type 11 is ignored, with err_pulse in the next cycle and no state change.
REQ-022 Pop: sample_req high with count > 0 registers the head into audio_out and decrements count; audio_valid is high in the following cycle.
REQ-023 Underflow: sample_req high with count = 0 sets audio_out to 16'h0000 (silence) and pulses audio_valid; count stays 0 and no err_pulse is raised.
REQ-024 Simultaneous push and pop in the same edge: count is unchanged when count > 0. When count = 0, the pop yields silence and the push is stored (no bypass).
REQ-025 HANGUP coincident with sample_req: the flush wins and audio_out is silence.
REQ-026 Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
REQ-027 The ring timer increments only in RINGING and is 24 bits wide.

Reset
REQ-028 While reset is low, the following hold regardless of clk:
  - call_state = IDLE, ring = 0;
  - FIFO count, head and tail = 0;
  - ctrl_hold = 0, so sessionBusy = 0;
  - audio_out = 0, audio_valid = 0, err_pulse = 0;
  - ring timer = 0.
REQ-029 Reset asserted mid-call discards FIFO contents. The first edge after release behaves as from IDLE.

Structure
REQ-030 Shared package session_pkg holds call-state encodings, opcode constants and the sendingToSession type codes; the transport receiver uses the same package.
REQ-031 The FIFO is the sub-module session_fifo (push, pop, flush, count, full, empty).
REQ-032 The state machine and ring timer remain in session_rcv.

Verification
REQ-033 Answer path: RING then ANSWER (0x0100, 0x0200), then audio 0x1234, 0x5678, then two sample_req. Required: call_state 01 then 10; audio_out 0x1234 then 0x5678, each with an audio_valid pulse.
REQ-034 Overflow, FIFO_DEPTH=8, CONNECTED, no pops: after 8 audio words sessionBusy = 1. Holding a 9th word gives err_pulse, and count stays 8.
REQ-035 Underflow: sample_req with an empty FIFO gives audio_out 0x0000 and audio_valid 1, with no err_pulse.
REQ-036 Timeout, RING_TIMEOUT=16: RING only. Required: ring = 1 for 16 cycles, then call_state IDLE; a later ANSWER gives err_pulse.
REQ-037 Flush: 3 samples queued, then HANGUP (0x0300) together with sample_req. Required: call_state IDLE, count 0, audio_out 0x0000; sessionBusy high for exactly one cycle.
REQ-038 Reset mid-call: reset low for 3 cycles with 4 samples queued. Required: all outputs at reset values asynchronously; IDLE after release.

Source files
------------

// File: rtl/session_pkg.sv
// session_pkg: encodings shared between the session receiver and the
// transport receiver (call states, control opcodes, word type codes).
package session_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RINGING   = 2'b01,
        ST_CONNECTED = 2'b10
    } call_state_e;

    // sendingToSession word type codes
    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_AUDIO = 2'b01;
    localparam logic [1:0] W_CTRL  = 2'b10;
    localparam logic [1:0] W_RSVD  = 2'b11;

    // control word opcodes (data[15:8])
    localparam logic [7:0] OP_RING   = 8'h01;
    localparam logic [7:0] OP_ANSWER = 8'h02;
    localparam logic [7:0] OP_HANGUP = 8'h03;

endpackage

// File: rtl/session_fifo.sv
// session_fifo: audio sample FIFO, DEPTH entries of 16 bits (power of two).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write strobe and data (ignored when full)
//   pop_i              advance head (ignored when empty)
//   flush_i            empty the FIFO; overrides push and pop
//   rdata_o            current head entry (combinational)
//   count_o, full_o, empty_o  occupancy
module session_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [15:0]   wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [15:0]   rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + AW'(1);
            if (do_pop)  head_q <= head_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/session_rcv.sv
// session_rcv: call-session receiver. Runs the IDLE/RINGING/CONNECTED call
// state machine from control words, queues audio samples while connected and
// plays them out on sample_req (silence on underflow).
// Ports:
//   clk, reset (async active-low)
//   sendingToSession[1:0], data[15:0]  word from transport receiver
//   sessionBusy                         backpressure (word not accepted)
//   sample_req                          pop strobe from audio side
//   audio_out[15:0], audio_valid        played sample and its pulse
//   call_state[1:0], ring               call status
//   err_pulse                           rejected / illegal word, one cycle later
module session_rcv
    import session_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [23:0] RING_TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sendingToSession,
    input  logic [15:0] data,
    output logic        sessionBusy,
    input  logic        sample_req,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic [1:0]  call_state,
    output logic        ring,
    output logic        err_pulse
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    call_state_e   state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic          ctrl_hold_q, err_q, err_d;
    logic [15:0]   audio_out_q;
    logic          audio_valid_q;

    logic          presented, accept, flush, ctrl_err, push, pop;
    logic [7:0]    opcode;
    logic [15:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [7:0]    unused_rsvd;

    assign unused_rsvd = data[7:0];
    assign opcode      = data[15:8];
    assign sessionBusy = fifo_full || ctrl_hold_q;
    assign presented   = (sendingToSession != W_NONE);
    assign accept      = presented && !sessionBusy;
    // Audio outside CONNECTED is accepted but dropped without error.
    assign push        = accept && (sendingToSession == W_AUDIO) && (state_q == ST_CONNECTED);
    assign pop         = sample_req && !fifo_empty && !flush;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        flush    = 1'b0;
        ctrl_err = 1'b0;
        if (state_q == ST_RINGING) begin
            timer_d = timer_q + 24'd1;
            if (timer_q == RING_TIMEOUT - 24'd1) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        end
        // A legal control word overrides a coincident timeout.
        if (accept && sendingToSession == W_CTRL) begin
            case (opcode)
                OP_RING: begin
                    if (state_q == ST_IDLE) begin
                        state_d = ST_RINGING;
                        timer_d = '0;
                    end else begin
                        ctrl_err = 1'b1;
                    end
                end
                OP_ANSWER: begin
                    if (state_q == ST_RINGING) state_d = ST_CONNECTED;
                    else                       ctrl_err = 1'b1;
                end
                OP_HANGUP: begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end
                default: ctrl_err = 1'b1;
            endcase
        end
        err_d = (presented && sessionBusy) ||
                (accept && sendingToSession == W_RSVD) || ctrl_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            ctrl_hold_q   <= 1'b0;
            err_q         <= 1'b0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ctrl_hold_q   <= accept && (sendingToSession == W_CTRL);
            err_q         <= err_d;
            audio_valid_q <= sample_req;
            // Empty FIFO or flush plays silence.
            if (sample_req) audio_out_q <= pop ? fifo_rdata : 16'h0000;
        end
    end

    session_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (data),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign call_state  = state_q;
    assign ring        = (state_q == ST_RINGING);
    assign err_pulse   = err_q;
    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;

endmodule

// File: tb/tb_session_rcv.sv
module tb_session_rcv;

    localparam int DEPTH = 8;
    localparam int RT    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  sendingToSession = 2'b00;
    logic [15:0] data = 16'h0;
    logic        sample_req = 1'b0;
    logic        sessionBusy, audio_valid, ring, err_pulse;
    logic [15:0] audio_out;
    logic [1:0]  call_state;

    int checks = 0;
    int errors = 0;

    session_rcv #(.FIFO_DEPTH(DEPTH), .RING_TIMEOUT(24'd16)) dut (
        .clk              (clk),
        .reset            (reset),
        .sendingToSession (sendingToSession),
        .data             (data),
        .sessionBusy      (sessionBusy),
        .sample_req       (sample_req),
        .audio_out        (audio_out),
        .audio_valid      (audio_valid),
        .call_state       (call_state),
        .ring             (ring),
        .err_pulse        (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: call state as an int, sample queue, cycles spent ringing.
    int          m_state = 0;
    int          m_ring_cycles = 0;
    logic [15:0] m_q[$];
    bit          m_hold = 0, m_err = 0, m_aval = 0;
    logic [15:0] m_aout = 16'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_ring_cycles = 0; m_q.delete();
            m_hold = 0; m_err = 0; m_aval = 0; m_aout = 16'h0;
        end else begin
            bit busy, acc, flush;
            int n_state;
            busy    = (m_q.size() == DEPTH) || m_hold;
            acc     = (sendingToSession != 0) && !busy;
            m_err   = (sendingToSession != 0) && busy;
            m_hold  = acc && (sendingToSession == 2);
            flush   = 0;
            n_state = m_state;
            if (m_state == 1) begin
                m_ring_cycles++;
                if (m_ring_cycles == RT) n_state = 0;
            end
            if (acc && sendingToSession == 3) m_err = 1;
            if (acc && sendingToSession == 2) begin
                case (data[15:8])
                    8'h01: if (m_state == 0) begin n_state = 1; m_ring_cycles = 0; end else m_err = 1;
                    8'h02: if (m_state == 1) n_state = 2; else m_err = 1;
                    8'h03: begin n_state = 0; flush = 1; end
                    default: m_err = 1;
                endcase
            end
            m_aval = sample_req;
            if (sample_req) begin
                if (flush || m_q.size() == 0) m_aout = 16'h0;
                else m_aout = m_q.pop_front();
            end
            if (flush) m_q.delete();
            if (acc && sendingToSession == 1 && m_state == 2) m_q.push_back(data);
            m_state = n_state;
        end
    end

    always @(negedge clk) begin
        chk("cmp call_state", 32'(call_state), 32'(m_state));
        chk("cmp ring", 32'(ring), 32'(m_state == 1));
        chk("cmp sessionBusy", 32'(sessionBusy), 32'((m_q.size() == DEPTH) || m_hold));
        chk("cmp err_pulse", 32'(err_pulse), 32'(m_err));
        chk("cmp audio_valid", 32'(audio_valid), 32'(m_aval));
        chk("cmp audio_out", 32'(audio_out), 32'(m_aout));
    end

    task automatic step(input logic [1:0] t, input logic [15:0] d, input logic sr);
        sendingToSession = t;
        data = d;
        sample_req = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        #12;
        chk("rst call_state", 32'(call_state), 32'd0);
        chk("rst busy", 32'(sessionBusy), 32'd0);
        chk("rst audio", 32'({audio_valid, err_pulse, ring, audio_out}), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        step(0, 16'h0, 0);

        // answer path
        step(2, 16'h0100, 0);
        chk("ring state", 32'(call_state), 32'd1);
        chk("ring busy hold", 32'(sessionBusy), 32'd1);
        step(0, 16'h0, 0);
        step(2, 16'h0200, 0);
        chk("answer state", 32'(call_state), 32'd2);
        step(0, 16'h0, 0);
        step(1, 16'h1234, 0);
        step(1, 16'h5678, 0);
        step(0, 16'h0, 1);
        chk("pop1 data", 32'(audio_out), 32'h1234);
        chk("pop1 valid", 32'(audio_valid), 32'd1);
        step(0, 16'h0, 1);
        chk("pop2 data", 32'(audio_out), 32'h5678);

        // underflow
        step(0, 16'h0, 1);
        chk("uflow data", 32'(audio_out), 32'h0);
        chk("uflow valid", 32'(audio_valid), 32'd1);
        chk("uflow err", 32'(err_pulse), 32'd0);

        // overflow
        for (int i = 0; i < 8; i++) step(1, 16'hA000 + 16'(i), 0);
        chk("full busy", 32'(sessionBusy), 32'd1);
        step(1, 16'hA008, 0);
        chk("ovf err", 32'(err_pulse), 32'd1);
        step(0, 16'h0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 16'h0, 1);
            chk("drain data", 32'(audio_out), 32'hA000 + 32'(i));
        end
        step(0, 16'h0, 1);
        chk("drain past end", 32'(audio_out), 32'h0);

        // push + pop on empty FIFO: silence now, stored word next
        step(1, 16'hBEEF, 1);
        chk("pp empty data", 32'(audio_out), 32'h0);
        step(0, 16'h0, 1);
        chk("pp stored", 32'(audio_out), 32'hBEEF);

        // flush with coincident sample_req
        step(1, 16'hC001, 0);
        step(1, 16'hC002, 0);
        step(1, 16'hC003, 0);
        step(2, 16'h0300, 1);
        chk("hangup state", 32'(call_state), 32'd0);
        chk("hangup data", 32'(audio_out), 32'h0);
        chk("hangup busy", 32'(sessionBusy), 32'd1);
        step(0, 16'h0, 0);
        chk("hangup busy1", 32'(sessionBusy), 32'd0);
        step(0, 16'h0, 1);
        chk("flushed", 32'(audio_out), 32'h0);

        // ring timeout
        step(2, 16'h0100, 0);
        n = 0;
        while (ring && n < 40) begin
            n++;
            step(0, 16'h0, 0);
        end
        chk("ring cycles", 32'(n), 32'd16);
        chk("timeout state", 32'(call_state), 32'd0);
        step(2, 16'h0200, 0);
        chk("late answer err", 32'(err_pulse), 32'd1);
        chk("late answer state", 32'(call_state), 32'd0);
        step(0, 16'h0, 0);
        step(3, 16'h0, 0);
        chk("rsvd err", 32'(err_pulse), 32'd1);
        step(0, 16'h0, 0);
        step(2, 16'h0700, 0);
        chk("bad op err", 32'(err_pulse), 32'd1);
        step(0, 16'h0, 0);

        // reset mid-call
        step(2, 16'h0100, 0);
        step(0, 16'h0, 0);
        step(2, 16'h0200, 0);
        step(0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(1, 16'hD001 + 16'(i), 0);
        step(2, 16'h0100, 1);
        chk("pre-rst data", 32'(audio_out), 32'hD001);
        chk("pre-rst err", 32'(err_pulse), 32'd1);
        step(0, 16'h0, 0);
        step(0, 16'h0, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst call_state", 32'(call_state), 32'd0);
        chk("arst outs", 32'({sessionBusy, audio_valid, err_pulse, ring, audio_out}), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step(0, 16'h0, 1);
        chk("post-rst data", 32'(audio_out), 32'h0);
        chk("post-rst state", 32'(call_state), 32'd0);
        step(1, 16'hE000, 0);
        chk("idle audio no err", 32'(err_pulse), 32'd0);
        step(0, 16'h0, 1);
        chk("idle audio dropped", 32'(audio_out), 32'h0);
        step(0, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
